ram_param: RTL and testbench

RAM_PARAM -- requirements
Module: ram_param

---
 rtl/ram_param_pkg.sv | 14 +
 rtl/ram_param_core.sv | 41 ++++
 rtl/ram_param.sv | 119 +++++++++++
 tb/tb_ram_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ram_param_pkg.sv
// Shared definitions for the byte-enabled RAM with a power-up clear sweep.
package ram_param_pkg;

    // Default geometry: 32 words of 32 bits.
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // CLEAR zeroes one word per cycle; READY serves read/write requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage : ram_param_pkg

// File: rtl/ram_param_core.sv
// Storage array: one single-write-port, single-read-port lane per byte.
// Each lane has its own registered read so the lanes map onto block RAM.
// There is no reset here; the contents are zeroed only by the caller's sweep.
module ram_param_core
    import ram_param_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_q;

        // Byte-lane write when enabled, and a read register that holds
        // between reads.
        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                lane_mem[wr_addr] <= wr_data[8*gi +: 8];
            end
            if (rd_en) begin
                lane_rd_q <= lane_mem[rd_addr];
            end
        end

        assign rd_data[8*gi +: 8] = lane_rd_q;
    end

endmodule : ram_param_core

// File: rtl/ram_param.sv
// Parameterised RAM with byte write enables, a one-cycle registered read,
// and a clear sweep that zeroes every word after reset or on request.
module ram_param
    import ram_param_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wena,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                clr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rvalid_q, rvalid_d;
    // Set by the first read after reset. Until then the core's read register
    // holds nothing meaningful, so rdata is forced to zero.
    logic                rd_ok_q, rd_ok_d;

    logic                wr_en;
    logic [BE_W-1:0]     wr_be;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;

    // Next state: either sweep one word or serve one request; clr wins over
    // any request made on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rd_ok_d  = rd_ok_q;
        wr_en    = 1'b0;
        wr_be    = '0;
        wr_addr  = addr;
        wr_data  = wdata;
        rd_en    = 1'b0;

        unique case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_be   = '1;
                wr_addr = cnt_q;
                wr_data = '0;
                if (clr) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (ena && wena) begin
                    wr_en = 1'b1;
                    wr_be = be;
                end else if (ena) begin
                    rd_en    = 1'b1;
                    rvalid_d = 1'b1;
                    rd_ok_d  = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State, sweep counter and output flags; reset aborts any sweep or access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rd_ok_q  <= rd_ok_d;
        end
    end

    ram_param_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr),
        .rd_data (rd_word)
    );

    assign rdata  = rd_ok_q ? rd_word : '0;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == CLEAR);

endmodule : ram_param

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: sweep length, byte-enabled writes, reads,
// clr during READY, reset mid-sweep and mid-access, and ignored requests.
module tb_ram_param;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wena;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;

    int checks_cnt;
    int errors_cnt;

    ram_param dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .wena   (wena),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .clr    (clr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Inputs change on the falling edge; the request is taken on the next rising edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        ena   = 1'b1;
        wena  = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
        @(negedge clk);
        ena   = 1'b0;
        wena  = 1'b0;
        chk("wr_rvalid", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
        ena  = 1'b1;
        wena = 1'b0;
        addr = a;
        @(negedge clk);
        ena  = 1'b0;
        chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
        chk($sformatf("rd_data[%0d]", a), rdata, exp);
    endtask

    // Counts falling edges with busy high, starting now; bounded so it cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n = 1'b0;
        ena   = 1'b0;
        wena  = 1'b0;
        be    = 4'h0;
        addr  = 5'd0;
        wdata = 32'd0;
        clr   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, busy},   32'd1);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata",  rdata,           32'd0);

        // Power-up sweep: exactly 32 busy cycles, then every word reads zero.
        rst_n = 1'b1;
        count_busy(n);
        chk("sweep_len", n, 32);
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 32'h0000_0000);
        end
        @(negedge clk);
        chk("idle_rvalid", {31'd0, rvalid}, 32'd0);

        // Full-word writes, then reads in reverse order.
        do_write(5'd0, 32'hffff_ffff, 4'hf);
        do_write(5'd4, 32'h8000_8000, 4'hf);
        do_read(5'd4, 32'h8000_8000);
        do_read(5'd0, 32'hffff_ffff);
        @(negedge clk);
        chk("post_rd_rvalid", {31'd0, rvalid}, 32'd0);
        chk("post_rd_hold",   rdata,           32'hffff_ffff);

        // Partial byte write and an all-zero byte-enable write.
        do_write(5'd5, 32'h1234_5678, 4'b0101);
        do_read(5'd5, 32'h0034_0078);
        do_write(5'd5, 32'haaaa_aaaa, 4'b0000);
        do_read(5'd5, 32'h0034_0078);

        // Request with ena low: no read happens and rdata holds.
        wena = 1'b0;
        addr = 5'd4;
        @(negedge clk);
        chk("ena0_rvalid", {31'd0, rvalid}, 32'd0);
        chk("ena0_hold",   rdata,           32'h0034_0078);

        // Top address and write-then-read on consecutive edges.
        do_write(5'd31, 32'hdead_beef, 4'hf);
        do_read(5'd31, 32'hdead_beef);
        do_write(5'd7, 32'h1122_3344, 4'b0011);
        do_read(5'd7, 32'h0000_3344);

        // clr in READY with a concurrent write to addr 4: the write is dropped.
        clr   = 1'b1;
        ena   = 1'b1;
        wena  = 1'b1;
        addr  = 5'd4;
        wdata = 32'h5555_5555;
        be    = 4'hf;
        @(negedge clk);
        clr  = 1'b0;
        wena = 1'b0;
        addr = 5'd31;
        // Keep a read request up for the whole sweep; none may be served.
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (rvalid !== 1'b0) chk("busy_rvalid", {31'd0, rvalid}, 32'd0);
            n++;
            @(negedge clk);
        end
        ena = 1'b0;
        chk("clr_sweep_len", n, 32);
        chk("busy_hold",     rdata, 32'h0000_3344);
        do_read(5'd4, 32'h0000_0000);
        do_read(5'd31, 32'h0000_0000);

        // Reset in the middle of a read access.
        do_write(5'd3, 32'hcafe_f00d, 4'hf);
        ena  = 1'b1;
        wena = 1'b0;
        addr = 5'd3;
        @(posedge clk);
        #2;
        ena = 1'b0;
        chk("acc_rvalid", {31'd0, rvalid}, 32'd1);
        chk("acc_rdata",  rdata,           32'hcafe_f00d);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("arst_rdata",  rdata,           32'd0);
        chk("arst_busy",   {31'd0, busy},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at sweep cycle 10; the next sweep must be full length.
        repeat (10) @(negedge clk);
        chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, busy}, 32'd1);
        chk("mid_rst_rdata", rdata,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        chk("rst_sweep_len", n, 32);
        do_read(5'd3, 32'h0000_0000);
        do_read(5'd0, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule : tb_ram_param
